// File: rtl/sd_clk_div_gen.sv
// sd_clk_div_gen: SD card clock divider computed from the CSD TRAN_SPEED byte, plus the divided clock generator.
// Define SD_CLK_DIV_ROUND_UP_EN to round the divide count up (sd_clk never exceeds rate_hz); default truncates.
module sd_clk_div_gen #(
  parameter int REF_HZ   = 50_000_000,
  parameter int CNT_W    = 16,
  parameter int MIN_DIV  = 2,
  parameter int INIT_DIV = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       tran_speed,
  input  logic             run,
  output logic             busy,
  output logic             ok,
  output logic             err,
  output logic             clamped,
  output logic [CNT_W-1:0] count,
  output logic             sd_clk,
  output logic             sd_clk_rise
);
`ifdef SD_CLK_DIV_ROUND_UP_EN
  localparam logic RUP = 1'b1;
`else
  localparam logic RUP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CHECK, DIV, ROUND, DONE} state_t;
  state_t state, state_n;
  logic [31:0] m10, pow, rate, dvsr, quo, rem;
  logic [32:0] rem_sh, q_fin;
  logic [4:0] step;
  logic bad, ge, ovf, clamp, fail;
  logic [CNT_W-1:0] ph, nxt, cur, h;
  logic act;
  always_comb begin
    case (tran_speed[6:3])
      4'h1: m10 = 32'd10;
      4'h2: m10 = 32'd12;
      4'h3: m10 = 32'd13;
      4'h4: m10 = 32'd15;
      4'h5: m10 = 32'd20;
      4'h6: m10 = 32'd25;
      4'h7: m10 = 32'd30;
      4'h8: m10 = 32'd35;
      4'h9: m10 = 32'd40;
      4'hA: m10 = 32'd45;
      4'hB: m10 = 32'd50;
      4'hC: m10 = 32'd55;
      4'hD: m10 = 32'd60;
      4'hE: m10 = 32'd70;
      4'hF: m10 = 32'd80;
      default: m10 = 32'd0;
    endcase
    pow = tran_speed[1:0] == 2'd0 ? 32'd10_000 :
          tran_speed[1:0] == 2'd1 ? 32'd100_000 :
          tran_speed[1:0] == 2'd2 ? 32'd1_000_000 : 32'd10_000_000;
    rate = m10 * pow;
    bad = tran_speed[7] || tran_speed[6:3] == 4'd0 || tran_speed[2:0] > 3'd3;
    rem_sh = {rem, quo[31]};
    ge = rem_sh >= {1'b0, dvsr};
    q_fin = {1'b0, quo} + 33'(RUP && rem != 32'd0);
    ovf = (q_fin >> CNT_W) != 33'd0;
    clamp = q_fin < 33'(MIN_DIV);
    state_n = state == IDLE  ? (start ? CHECK : IDLE) :
              state == CHECK ? (bad ? DONE : DIV) :
              state == DIV   ? (step == 5'd31 ? ROUND : DIV) :
              state == ROUND ? DONE : IDLE;
    busy = state != IDLE;
    ok = state == DONE && !fail;
    err = state == DONE && fail;
    h = cur >> 1;
    nxt = ph + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= CNT_W'(INIT_DIV);
      clamped <= 1'b0;
      fail <= 1'b0;
      step <= 5'd0;
      dvsr <= 32'd0;
      quo <= 32'd0;
      rem <= 32'd0;
    end else begin
      state <= state_n;
      if (state == CHECK) begin
        fail <= bad;
        dvsr <= rate;
        quo <= 32'(REF_HZ);
        rem <= 32'd0;
        step <= 5'd0;
      end else if (state == DIV) begin
        quo <= {quo[30:0], ge};
        rem <= ge ? 32'(rem_sh - {1'b0, dvsr}) : rem_sh[31:0];
        step <= step + 5'd1;
      end else if (state == ROUND) begin
        fail <= ovf;
        if (!ovf) begin
          count <= clamp ? CNT_W'(MIN_DIV) : q_fin[CNT_W-1:0];
          clamped <= clamp;
        end
      end
    end
  end
  // A new count is only picked up when a period (or a fresh run) begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      act <= 1'b0;
      ph <= '0;
      cur <= CNT_W'(INIT_DIV);
      sd_clk <= 1'b0;
      sd_clk_rise <= 1'b0;
    end else begin
      sd_clk_rise <= 1'b0;
      if (run && (!act || nxt == cur)) begin
        act <= 1'b1;
        cur <= count;
        ph <= '0;
        sd_clk <= 1'b1;
        sd_clk_rise <= 1'b1;
      end else if (act && ((!run && nxt >= h) || nxt == cur)) begin
        act <= 1'b0;
        ph <= '0;
        sd_clk <= 1'b0;
      end else if (act) begin
        ph <= nxt;
        sd_clk <= nxt < h;
      end
    end
  end
endmodule
